// File: rtl/line_engine.sv
// rtl/line_engine.sv - handshaked Bresenham line / full-screen fill pixel engine
//
// Accepts one command at a time (cmd_valid & cmd_ready) and emits one
// framebuffer pixel per clock, then pulses done for one cycle.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        : command handshake
//   cmd_mode                     : 0 = line x0,y0 -> x1,y1 ; 1 = fill screen
//   x0, x1, y0, y1, color_in     : command operands, latched at handshake
//   abort                        : cancel the command in flight (no done)
//   x, y, pixel_color, pixel_write : registered framebuffer pixel port
//   busy, done                   : activity flag, one-cycle completion pulse
module line_engine #(
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_mode,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic           color_in,
    input  logic           abort,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pixel_color,
    output logic           pixel_write,
    output logic           busy,
    output logic           done
);

    // Two guard bits keep dx + dy and err updates exact at full-scale endpoints.
    localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] X_ONE  = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DRAW, S_FILL, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  color_q, color_d;
    logic [X_W-1:0]        x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0]        y0_q, y0_d, y1_q, y1_d;
    logic signed [W-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic [X_W-1:0]        cur_x_q, cur_x_d;
    logic [Y_W-1:0]        cur_y_q, cur_y_d;
    logic                  pix_write_q, pix_write_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Setup terms and the Bresenham step, all from registered state.
    logic [X_W-1:0]        adx;
    logic [Y_W-1:0]        ady;
    logic [W-1:0]          ady_ext;
    logic signed [W-1:0]   dx_init, dy_init, err_n;
    logic signed [W:0]     e2, dx_e, dy_e;
    logic                  step_x, step_y;
    logic [X_W-1:0]        nx;
    logic [Y_W-1:0]        ny;

    always_comb begin
        adx     = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ady     = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        ady_ext = {{(W-Y_W){1'b0}}, ady};
        dx_init = {{(W-X_W){1'b0}}, adx};
        dy_init = -ady_ext;

        // e2 gets one extra bit so doubling err can never wrap.
        e2      = {err_q, 1'b0};
        dx_e    = {dx_q[W-1], dx_q};
        dy_e    = {dy_q[W-1], dy_q};
        step_x  = (e2 >= dy_e);
        step_y  = (e2 <= dx_e);

        err_n   = err_q;
        nx      = cur_x_q;
        ny      = cur_y_q;
        if (step_x) begin
            err_n = err_n + dy_q;
            nx    = sx_neg_q ? (cur_x_q - X_ONE) : (cur_x_q + X_ONE);
        end
        if (step_y) begin
            err_n = err_n + dx_q;
            ny    = sy_neg_q ? (cur_y_q - Y_ONE) : (cur_y_q + Y_ONE);
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        color_d     = color_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        pix_write_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    color_d = color_in;
                    x0_d    = x0;
                    x1_d    = x1;
                    y0_d    = y0;
                    y1_d    = y1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mode_q) begin
                    cur_x_d     = '0;
                    cur_y_d     = '0;
                    pix_write_d = 1'b1;
                    state_d     = S_FILL;
                end else begin
                    dx_d        = dx_init;
                    dy_d        = dy_init;
                    err_d       = dx_init + dy_init;
                    sx_neg_d    = (x1_q < x0_q);
                    sy_neg_d    = (y1_q < y0_q);
                    cur_x_d     = x0_q;
                    cur_y_d     = y0_q;
                    pix_write_d = !((x0_q > X_LAST) || (y0_q > Y_LAST));
                    state_d     = S_DRAW;
                end
            end
            S_DRAW: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if ((cur_x_q == x1_q) && (cur_y_q == y1_q)) begin
                    state_d = S_DONE;
                end else begin
                    cur_x_d     = nx;
                    cur_y_d     = ny;
                    err_d       = err_n;
                    // Off-screen pixels are still walked, just not written.
                    pix_write_d = !((nx > X_LAST) || (ny > Y_LAST));
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if ((cur_x_q == X_LAST) && (cur_y_q == Y_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    if (cur_x_q == X_LAST) begin
                        cur_x_d = '0;
                        cur_y_d = cur_y_q + Y_ONE;
                    end else begin
                        cur_x_d = cur_x_q + X_ONE;
                    end
                    pix_write_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_SETUP) || (state_d == S_DRAW) || (state_d == S_FILL);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            color_q     <= 1'b0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            pix_write_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            color_q     <= color_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            pix_write_q <= pix_write_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign x           = cur_x_q;
    assign y           = cur_y_q;
    assign pixel_color = color_q;
    assign pixel_write = pix_write_q;

endmodule

// File: doc/line_engine.md
# line_engine

Parametrised, handshaked successor to the free-running line drawer. It accepts one drawing command at a time: either a Bresenham line in any octant, or a full-screen fill/clear. It emits one framebuffer pixel write per clock and pulses `done` when the command completes. It sits between command sources (animation FSM, test pattern sequencer) and the VGA framebuffer pixel port (`x`, `y`, `pixel_color`, `pixel_write`).

## Interface
Parameters:
- `X_W`, default 10: x coordinate width.
- `Y_W`, default 9: y coordinate width.
- `X_MAX`, default 639: largest writable x.
- `Y_MAX`, default 479: largest writable y.

Ports:
- `clk`, in, 1: system clock (CLOCK_50).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: engine idle; the command is accepted on `cmd_valid & cmd_ready`.
- `cmd_mode`, in, 1: 0 = line, 1 = fill screen.
- `x0`, `x1`, in, X_W: line endpoint x coordinates (unsigned).
- `y0`, `y1`, in, Y_W: line endpoint y coordinates (unsigned).
- `color_in`, in, 1: colour for the command.
- `abort`, in, 1: synchronous cancel of the current command.
- `x`, out, X_W: pixel x coordinate.
- `y`, out, Y_W: pixel y coordinate.
- `pixel_color`, out, 1: pixel colour.
- `pixel_write`, out, 1: pixel write strobe.
- `busy`, out, 1: high in SETUP, DRAW and FILL.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- States and transitions:
  - IDLE: go to SETUP on handshake.
  - SETUP: go to DRAW (mode 0) or FILL (mode 1).
  - DRAW or FILL: go to DONE after the last pixel.
  - DONE: go to IDLE.
- All inputs (coordinates, mode, colour) are latched at the handshake. Input changes after that have no effect.
- SETUP computes:
  - `dx = |x1-x0|`, `dy = -|y1-y0|`.
  - `sx`, `sy` = +1/-1. On equality, direction is +1.
  - `err = dx + dy`.
  - All signed arithmetic is in max(X_W,Y_W)+2 bits, so there is no overflow at full-scale endpoints.
- DRAW, each cycle:
  - Output the current (x,y). If it equals (x1,y1), this is the last pixel.
  - Otherwise, with `e2 = 2*err`:
    - if `e2 >= dy`: `err += dy`, `x += sx`;
    - if `e2 <= dx`: `err += dx`, `y += sy`.
    - Both updates may apply in the same cycle.
- Pixel count is N = max(dx,|dy|)+1. A zero-length line (x0==x1, y0==y1) gives N=1.
- Clipping: a pixel with x > X_MAX or y > Y_MAX is still traversed but output with `pixel_write=0`.
- FILL:
  - Raster scan, x fastest: x 0..X_MAX, then y 0..Y_MAX.
  - `pixel_color = color_in` for every pixel.
  - N = (X_MAX+1)(Y_MAX+1).
- `abort` in SETUP, DRAW or FILL:
  - Next cycle the state is IDLE, `pixel_write=0`, and no `done` pulse is produced.
  - `abort` in IDLE or DONE is ignored.
- `cmd_valid` while busy is ignored; there is no queueing.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready=1`; `x`, `y`, `pixel_color`, `pixel_write`, `busy` and `done` all 0; state IDLE.
- Reset asserted mid-command: outputs take reset values immediately. The in-flight command is lost and no `done` is produced.
- Cycle numbering (handshake edge = cycle 0):
  - `cmd_ready` drops and `busy` rises in cycle 1 (SETUP).
  - Pixel k (k = 0..N-1) is presented in cycle 2+k with `pixel_write` high, unless clipped.
  - `done=1` and `busy=0` in cycle 2+N.
  - `cmd_ready=1` in cycle 3+N.
  - Command-to-command throughput is N+3 cycles.
- `pixel_write`, `x` and `y` are valid in the same cycle. The framebuffer samples them at the next edge.

## Test plan
- Horizontal line, (160,240)->(480,240):
  - 321 writes, x runs 160..480 incrementing by 1, y fixed at 240.
  - `done` in cycle 323; `cmd_ready` returns in cycle 324.
- Reversed vertical line, (320,360)->(320,120):
  - 241 writes, y runs 360 down to 120, x fixed at 320.
- Slope 2 with clipping, (0,0)->(240,480):
  - 481 pixels traversed; x increments every second step.
  - Final pixel (240,480) is output with `pixel_write=0`, so 480 writes.
  - `done` still pulses once.
- Single point, (5,7)->(5,7):
  - Exactly one write at (5,7) in cycle 2; `done` in cycle 3.
- FILL with X_MAX=3, Y_MAX=1, `color_in=0`:
  - 8 writes, in order (0,0)..(3,0),(0,1)..(3,1), all with `pixel_color=0`.
  - `cmd_valid` pulsed mid-fill is ignored.
- Abort and reset:
  - `abort` at pixel 10 of the 321-pixel line: IDLE next cycle, no `done`.
  - A new command is then accepted and completes normally.
  - `reset_n` low mid-line: all outputs reset asynchronously.
